// File: rtl/pio_pkg.sv
// Shared constants for the parallel output port: the register address map
// and the width of the word address.
package pio_pkg;

    localparam int unsigned PIO_ADDR_W = 3;

    localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_DATA   = 3'd0;
    localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_SET    = 3'd1;
    localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_CLEAR  = 3'd2;
    localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_MASK   = 3'd3;
    localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_PERIOD = 3'd4;
    localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_STATUS = 3'd5;

endpackage

// File: rtl/pio_blink_prescaler.sv
// Blink prescaler: the phase toggles every period_i+1 cycles. A period of
// zero holds everything idle, and restart_i realigns the counter and phase.
module pio_blink_prescaler #(
    parameter int unsigned PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic                restart_i,
    output logic                phase_o
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        phase_d = phase_q;
        if (restart_i || (period_i == '0)) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == period_i) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/pio_out_blink.sv
// Avalon-MM parallel output port with atomic set/clear and per-bit hardware
// blink. The pin value is registered so the pins never glitch.
module pio_out_blink
    import pio_pkg::*;
#(
    parameter int unsigned             WIDTH     = 27,
    parameter logic [WIDTH-1:0]        RESET_VAL = '0,
    parameter int unsigned             PERIOD_W  = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  chipselect,
    input  logic [PIO_ADDR_W-1:0] address,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [WIDTH-1:0]      out_port
);

    logic [WIDTH-1:0]    data_q, data_d;
    logic [WIDTH-1:0]    mask_q, mask_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [WIDTH-1:0]    out_q, out_d;
    logic                wr;
    logic                restart;
    logic                phase;
    logic [WIDTH-1:0]    wd_data;
    logic [PERIOD_W-1:0] wd_period;
    logic                unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wd_data   = writedata[WIDTH-1:0];
    assign wd_period = writedata[PERIOD_W-1:0];
    assign unused_wd = ^writedata;
    assign restart   = wr && (address == PIO_ADDR_PERIOD);

    always_comb begin
        data_d   = data_q;
        mask_d   = mask_q;
        period_d = period_q;
        if (wr) begin
            case (address)
                PIO_ADDR_DATA:   data_d   = wd_data;
                PIO_ADDR_SET:    data_d   = data_q | wd_data;
                PIO_ADDR_CLEAR:  data_d   = data_q & ~wd_data;
                PIO_ADDR_MASK:   mask_d   = wd_data;
                PIO_ADDR_PERIOD: period_d = wd_period;
                default:         ;
            endcase
        end
    end

    // Pin value uses the pre-edge DATA/MASK/phase, so pins lag by one cycle.
    assign out_d = data_q ^ (mask_q & {WIDTH{phase}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q   <= RESET_VAL;
            mask_q   <= '0;
            period_q <= '0;
            out_q    <= RESET_VAL;
        end else begin
            data_q   <= data_d;
            mask_q   <= mask_d;
            period_q <= period_d;
            out_q    <= out_d;
        end
    end

    pio_blink_prescaler #(
        .PERIOD_W (PERIOD_W)
    ) u_prescaler (
        .clk       (clk),
        .reset     (reset),
        .period_i  (period_q),
        .restart_i (restart),
        .phase_o   (phase)
    );

    always_comb begin
        readdata = '0;
        case (address)
            PIO_ADDR_DATA:   readdata = 32'(data_q);
            PIO_ADDR_MASK:   readdata = 32'(mask_q);
            PIO_ADDR_PERIOD: readdata = 32'(period_q);
            PIO_ADDR_STATUS: readdata = {31'd0, phase};
            default:         readdata = '0;
        endcase
    end

    assign out_port = out_q;

endmodule

// File: tb/tb_pio_out_blink.sv
// Directed bench for pio_out_blink: a cycle model derived from the register
// rules, checked every cycle, plus hand-computed spot checks.
module tb_pio_out_blink;

    localparam int unsigned W  = 27;
    localparam int unsigned PW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          chipselect = 1'b0;
    logic [2:0]    address = 3'd0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic [W-1:0]  out_port;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    bit          started  = 1'b0;

    pio_out_blink #(
        .WIDTH     (W),
        .RESET_VAL (27'h5),
        .PERIOD_W  (PW)
    ) dut (
        .clk        (clk),
        .reset      (rst),
        .chipselect (chipselect),
        .address    (address),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    // Model: phase after k edges since the last restart is floor(k/(P+1)) mod 2.
    logic [W-1:0]  m_data   = 27'h5;
    logic [W-1:0]  m_mask   = '0;
    logic [PW-1:0] m_period = '0;
    logic [W-1:0]  m_out    = 27'h5;
    longint        m_k      = 0;

    function automatic bit phase_of(input longint k, input logic [PW-1:0] p);
        if (p == '0) return 1'b0;
        return bit'((k / (longint'(p) + 1)) % 2);
    endfunction

    function automatic logic [31:0] model_rd(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_data);
            3'd3:    return 32'(m_mask);
            3'd4:    return 32'(m_period);
            3'd5:    return {31'd0, phase_of(m_k, m_period)};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data = 27'h5; m_mask = '0; m_period = '0; m_out = 27'h5; m_k = 0;
        end else begin
            m_out = m_data ^ (m_mask & {W{phase_of(m_k, m_period)}});
            m_k = m_k + 1;
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_data = writedata[W-1:0];
                    3'd1: m_data = m_data | writedata[W-1:0];
                    3'd2: m_data = m_data & ~writedata[W-1:0];
                    3'd3: m_mask = writedata[W-1:0];
                    3'd4: begin m_period = writedata[PW-1:0]; m_k = 0; end
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started && !rst) begin
            check("model_out_port", 32'(out_port), 32'(m_out));
            check("model_readdata", readdata, model_rd(address));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #2;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(name, readdata, exp);
    endtask

    initial begin
        int unsigned guard;
        tick(2);
        rst = 1'b0;
        started = 1'b1;

        // 1: reset values
        check("reset_out_port", 32'(out_port), 32'h5);
        rd_check("reset_data", 3'd0, 32'h5);
        rd_check("reset_mask", 3'd3, 32'h0);
        rd_check("reset_period", 3'd4, 32'h0);
        rd_check("reset_status", 3'd5, 32'h0);

        // 2: DATA / SET / CLEAR
        bus_wr(3'd0, 32'h0F0);
        rd_check("data_write", 3'd0, 32'h0F0);
        tick(1);
        check("data_write_pin", 32'(out_port), 32'h0F0);
        bus_wr(3'd1, 32'h00F);
        rd_check("data_set", 3'd0, 32'h0FF);
        check("data_set_pin_lag", 32'(out_port), 32'h0F0);
        tick(1);
        check("data_set_pin", 32'(out_port), 32'h0FF);
        bus_wr(3'd2, 32'h030);
        rd_check("data_clear", 3'd0, 32'h0CF);
        tick(1);
        check("data_clear_pin", 32'(out_port), 32'h0CF);

        // 3: blink with PERIOD=3 (toggle every 4 cycles)
        bus_wr(3'd0, 32'h0);
        bus_wr(3'd3, 32'h3);
        bus_wr(3'd4, 32'h3);
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (i == 4) check("blink_i4", 32'(out_port[1:0]), 32'h0);
            if (i == 4) rd_check("blink_status_i4", 3'd5, 32'h1);
            if (i == 5) check("blink_i5", 32'(out_port[1:0]), 32'h3);
            if (i == 8) check("blink_i8", 32'(out_port[1:0]), 32'h3);
            if (i == 8) rd_check("blink_status_i8", 3'd5, 32'h0);
            if (i == 9) check("blink_i9", 32'(out_port[1:0]), 32'h0);
        end

        // 4: restart with PERIOD=1, then blink off
        bus_wr(3'd4, 32'h1);
        rd_check("restart_status_k0", 3'd5, 32'h0);
        tick(2);
        rd_check("restart_status_k2", 3'd5, 32'h1);
        tick(2);
        rd_check("restart_status_k4", 3'd5, 32'h0);
        bus_wr(3'd4, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("blink_off_pin", 32'(out_port), 32'h0);
        end

        // 5: ignored addresses
        bus_wr(3'd0, 32'h123);
        bus_wr(3'd5, 32'hFFFF_FFFF);
        bus_wr(3'd6, 32'hFFFF_FFFF);
        bus_wr(3'd7, 32'hFFFF_FFFF);
        tick(1);
        rd_check("ign_data", 3'd0, 32'h123);
        rd_check("ign_rd_set", 3'd1, 32'h0);
        rd_check("ign_rd_clear", 3'd2, 32'h0);
        rd_check("ign_rd_6", 3'd6, 32'h0);
        rd_check("ign_rd_7", 3'd7, 32'h0);
        rd_check("ign_mask", 3'd3, 32'h3);
        rd_check("ign_period", 3'd4, 32'h0);
        check("ign_pin", 32'(out_port), 32'h123);

        // 6: asynchronous reset while blinking with phase=1
        bus_wr(3'd0, 32'h1FF);
        bus_wr(3'd4, 32'h2);
        address = 3'd5;
        guard = 0;
        while (readdata[0] !== 1'b1 && guard < 50) begin
            tick(1);
            guard++;
        end
        check("phase_wait_timeout", 32'(guard < 50), 32'h1);
        tick(1);
        check("blink_before_reset", 32'(out_port), 32'h1FC);
        rst = 1'b1;
        #1;
        check("async_reset_pin", 32'(out_port), 32'h5);
        rd_check("async_reset_status", 3'd5, 32'h0);
        rd_check("async_reset_data", 3'd0, 32'h5);
        tick(1);
        rst = 1'b0;
        tick(3);
        check("post_reset_pin", 32'(out_port), 32'h5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
